// File: rtl/hack_prog_rom_if.sv
// Program-load stream and instruction-fetch port shared by the HACK program ROM and its host/CPU.
// The master side streams program words and drives pc; the slave side (the ROM) returns inst.
interface hack_prog_rom_if #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 15
) ();

  logic              load_valid;
  logic              load_ready;
  logic [DATA_W-1:0] load_data;
  logic              load_last;
  logic [ADDR_W-1:0] pc;
  logic [DATA_W-1:0] inst;

  modport master (
    output load_valid,
    output load_data,
    output load_last,
    output pc,
    input  load_ready,
    input  inst
  );

  modport slave (
    input  load_valid,
    input  load_data,
    input  load_last,
    input  pc,
    output load_ready,
    output inst
  );

endinterface

// File: rtl/hack_prog_rom.sv
// Program ROM and boot sequencer for the HACK CPU: streams a program in, holds the CPU in reset, then serves fetches.
// Optional halt detection (pc parked for HALT_CYCLES cycles in RUN) is enabled by defining HACK_HALT_DETECT_EN.
module hack_prog_rom #(
  parameter int DATA_W       = 16,
  parameter int ADDR_W       = 15,
  parameter int DEPTH        = 16384,
  parameter int RESET_CYCLES = 2,
  parameter int HALT_CYCLES  = 8
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              load_start,
  input  logic              run_start,
  hack_prog_rom_if.slave    bus,
  output logic              cpu_reset,
  output logic [ADDR_W:0]   loaded_count,
  output logic              overflow,
  output logic              busy,
  output logic              halted
);

  localparam int AW     = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int HOLD_W = (RESET_CYCLES > 1) ? $clog2(RESET_CYCLES) : 1;
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(RESET_CYCLES - 1);
  localparam logic [ADDR_W:0]   LAST_ADDR = (ADDR_W + 1)'(DEPTH - 1);
  localparam logic [ADDR_W:0]   FULL      = (ADDR_W + 1)'(DEPTH);

  if (DEPTH < 2 || DEPTH > (1 << ADDR_W)) begin : g_bad_depth
    $error("hack_prog_rom: DEPTH must be in 2..2**ADDR_W");
  end
  if (RESET_CYCLES < 1) begin : g_bad_reset_cycles
    $error("hack_prog_rom: RESET_CYCLES must be at least 1");
  end
  if (HALT_CYCLES < 1) begin : g_bad_halt_cycles
    $error("hack_prog_rom: HALT_CYCLES must be at least 1");
  end

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    HOLD,
    RUN
  } state_t;

  state_t            state;
  state_t            state_next;
  logic [HOLD_W-1:0] hold_cnt;
  logic [ADDR_W:0]   wr_ptr;
  logic              accept;
  logic              end_of_load;
  logic              rd_block;
  logic [DATA_W-1:0] mem [DEPTH];

  // A restart request outranks a word offered in the same cycle; that word is dropped.
  assign accept      = (state == LOAD) && bus.load_valid && !load_start;
  assign end_of_load = accept && (bus.load_last || (wr_ptr == LAST_ADDR));

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE: begin
        if (load_start)     state_next = LOAD;
        else if (run_start) state_next = HOLD;
      end
      LOAD: begin
        if (load_start)       state_next = LOAD;
        else if (end_of_load) state_next = HOLD;
      end
      HOLD: begin
        if (load_start)                  state_next = LOAD;
        else if (hold_cnt == HOLD_LAST)  state_next = RUN;
      end
      RUN: begin
        if (load_start)     state_next = LOAD;
        else if (run_start) state_next = HOLD;
      end
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    cpu_reset      = (state != RUN);
    bus.load_ready = (state == LOAD);
    busy           = (state == LOAD) || (state == HOLD);
  end

  always_ff @(posedge clk) begin
    if (!reset_n || state != HOLD) begin
      hold_cnt <= '0;
    end else if (hold_cnt != HOLD_LAST) begin
      hold_cnt <= hold_cnt + 1'b1;
    end
  end

  // wr_ptr doubles as the word count; the FSM leaves LOAD before it could pass DEPTH.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      wr_ptr   <= '0;
      overflow <= 1'b0;
    end else if (load_start) begin
      wr_ptr   <= '0;
      overflow <= 1'b0;
    end else if (accept) begin
      if (wr_ptr != FULL) wr_ptr <= wr_ptr + 1'b1;
      if (!bus.load_last && wr_ptr == LAST_ADDR) overflow <= 1'b1;
    end
  end

  assign loaded_count = wr_ptr;

  always_ff @(posedge clk) begin
    if (accept) mem[wr_ptr[AW-1:0]] <= bus.load_data;
  end

  always_ff @(posedge clk) begin
    rd_block <= !reset_n;
  end

  // Falling-edge read gives the CPU a settled inst by its next rising edge.
  always_ff @(negedge clk) begin
    if (rd_block) begin
      bus.inst <= '0;
    end else if ({1'b0, bus.pc} < wr_ptr) begin
      bus.inst <= mem[bus.pc[AW-1:0]];
    end else begin
      bus.inst <= '0;
    end
  end

`ifdef HACK_HALT_DETECT_EN
  localparam int HC_W = $clog2(HALT_CYCLES + 1);
  localparam logic [HC_W-1:0] HC_MAX  = HC_W'(HALT_CYCLES);
  localparam logic [HC_W-1:0] HC_LAST = HC_W'(HALT_CYCLES - 1);

  logic [ADDR_W-1:0] prev_pc;
  logic [HC_W-1:0]   same_cnt;
  logic              halted_q;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      prev_pc  <= '0;
      same_cnt <= '0;
      halted_q <= 1'b0;
    end else begin
      prev_pc <= bus.pc;
      if (load_start || run_start) begin
        same_cnt <= '0;
        halted_q <= 1'b0;
      end else if (state != RUN || bus.pc != prev_pc) begin
        same_cnt <= '0;
      end else if (same_cnt != HC_MAX) begin
        same_cnt <= same_cnt + 1'b1;
        if (same_cnt == HC_LAST) halted_q <= 1'b1;
      end
    end
  end

  assign halted = halted_q;
`else
  assign halted = 1'b0;
`endif

endmodule

// File: tb/tb_hack_prog_rom.sv
// Directed bench for hack_prog_rom (DEPTH=8): load/boot, backpressure, overflow, reload, re-boot and halt sequences.
module tb_hack_prog_rom;

  localparam int DATA_W       = 16;
  localparam int ADDR_W       = 15;
  localparam int DEPTH        = 8;
  localparam int RESET_CYCLES = 2;
  localparam int HALT_CYCLES  = 8;

`ifdef HACK_HALT_DETECT_EN
  localparam logic EXP_HALT = 1'b1;
`else
  localparam logic EXP_HALT = 1'b0;
`endif

  typedef struct {
    logic [ADDR_W-1:0] pc;
    logic [DATA_W-1:0] inst;
  } read_vec_t;

  logic            clk = 1'b0;
  logic            reset_n;
  logic            load_start;
  logic            run_start;
  logic            cpu_reset;
  logic [ADDR_W:0] loaded_count;
  logic            overflow;
  logic            busy;
  logic            halted;

  int checks = 0;
  int fails  = 0;

  hack_prog_rom_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) bus ();

  hack_prog_rom #(
    .DATA_W(DATA_W),
    .ADDR_W(ADDR_W),
    .DEPTH(DEPTH),
    .RESET_CYCLES(RESET_CYCLES),
    .HALT_CYCLES(HALT_CYCLES)
  ) dut (
    .clk(clk),
    .reset_n(reset_n),
    .load_start(load_start),
    .run_start(run_start),
    .bus(bus),
    .cpu_reset(cpu_reset),
    .loaded_count(loaded_count),
    .overflow(overflow),
    .busy(busy),
    .halted(halted)
  );

  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation did not finish, got timeout, required $finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      fails++;
      $display("[TB] FAIL %s: got 0x%0h, required 0x%0h", name, actual, expected);
    end
  endtask

  // Drives pc and waits for the falling-edge read to settle.
  task automatic applyStimulus(input logic [ADDR_W-1:0] pc_val);
    bus.pc = pc_val;
    @(negedge clk);
    #1;
  endtask

  task automatic streamWord(input logic [DATA_W-1:0] data, input logic last);
    bus.load_valid = 1'b1;
    bus.load_data  = data;
    bus.load_last  = last;
    tick();
    bus.load_valid = 1'b0;
    bus.load_last  = 1'b0;
  endtask

  task automatic pulseStart(input logic is_load);
    if (is_load) load_start = 1'b1;
    else         run_start  = 1'b1;
    tick();
    load_start = 1'b0;
    run_start  = 1'b0;
  endtask

  initial begin
    read_vec_t         basic_vec [6];
    read_vec_t         bp_vec    [5];
    read_vec_t         ovf_vec   [4];
    logic [DATA_W-1:0] basic_prog[3];
    logic [DATA_W-1:0] bp_prog   [4];

    basic_prog = '{16'h0002, 16'hEC10, 16'h0000};
    bp_prog    = '{16'h1111, 16'h2222, 16'h3333, 16'h4444};
    basic_vec  = '{'{15'd0, 16'h0002}, '{15'd1, 16'hEC10}, '{15'd2, 16'h0000},
                   '{15'd3, 16'h0000}, '{15'd5, 16'h0000}, '{15'd9, 16'h0000}};
    bp_vec     = '{'{15'd0, 16'h1111}, '{15'd1, 16'h2222}, '{15'd2, 16'h3333},
                   '{15'd3, 16'h4444}, '{15'd4, 16'h0000}};
    ovf_vec    = '{'{15'd0, 16'h0100}, '{15'd7, 16'h0107}, '{15'd8, 16'h0000},
                   '{15'h7FFF, 16'h0000}};

    reset_n        = 1'b0;
    load_start     = 1'b0;
    run_start      = 1'b0;
    bus.load_valid = 1'b0;
    bus.load_data  = '0;
    bus.load_last  = 1'b0;
    bus.pc         = '0;

    $display("[TB] reset and idle");
    tick();
    tick();
    checkOutput("rst_cpu_reset", cpu_reset, 1);
    checkOutput("rst_load_ready", bus.load_ready, 0);
    checkOutput("rst_loaded_count", loaded_count, 0);
    checkOutput("rst_overflow", overflow, 0);
    checkOutput("rst_busy", busy, 0);
    checkOutput("rst_halted", halted, 0);
    applyStimulus(15'd0);
    checkOutput("rst_inst", bus.inst, 0);
    reset_n = 1'b1;
    tick();
    checkOutput("idle_busy", busy, 0);
    checkOutput("idle_cpu_reset", cpu_reset, 1);

    $display("[TB] basic load and boot");
    pulseStart(1'b1);
    checkOutput("load_ready_in_load", bus.load_ready, 1);
    checkOutput("load_busy", busy, 1);
    checkOutput("load_count_start", loaded_count, 0);
    for (int i = 0; i < 3; i++) streamWord(basic_prog[i], i == 2);
    checkOutput("basic_ready_drop", bus.load_ready, 0);
    checkOutput("basic_count", loaded_count, 3);
    checkOutput("basic_hold_cyc1", cpu_reset, 1);
    tick();
    checkOutput("basic_hold_cyc2", cpu_reset, 1);
    tick();
    checkOutput("basic_run_cpu_reset", cpu_reset, 0);
    checkOutput("basic_run_busy", busy, 0);
    foreach (basic_vec[i]) begin
      applyStimulus(basic_vec[i].pc);
      checkOutput($sformatf("basic_inst_pc%0d", basic_vec[i].pc), bus.inst, basic_vec[i].inst);
    end

    $display("[TB] reload from run with backpressure");
    pulseStart(1'b1);
    checkOutput("bp_cpu_reset_reload", cpu_reset, 1);
    checkOutput("bp_count_cleared", loaded_count, 0);
    for (int i = 0; i < 7; i++) begin
      bus.load_valid = (i % 2 == 0);
      bus.load_data  = (i % 2 == 0) ? bp_prog[i / 2] : 16'hDEAD;
      bus.load_last  = (i == 6);
      tick();
      if (i == 3) checkOutput("bp_count_mid", loaded_count, 2);
    end
    bus.load_valid = 1'b0;
    bus.load_last  = 1'b0;
    checkOutput("bp_count", loaded_count, 4);
    checkOutput("bp_ready_drop", bus.load_ready, 0);
    tick();
    tick();
    checkOutput("bp_run", cpu_reset, 0);
    foreach (bp_vec[i]) begin
      applyStimulus(bp_vec[i].pc);
      checkOutput($sformatf("bp_inst_pc%0d", bp_vec[i].pc), bus.inst, bp_vec[i].inst);
    end

    $display("[TB] overflow without load_last");
    pulseStart(1'b1);
    for (int i = 0; i < 10; i++) begin
      bus.load_valid = 1'b1;
      bus.load_data  = 16'h0100 + DATA_W'(i);
      bus.load_last  = 1'b0;
      tick();
      if (i == 6) begin
        checkOutput("ovf_not_yet", overflow, 0);
        checkOutput("ovf_ready_before_full", bus.load_ready, 1);
      end
      if (i == 7) begin
        checkOutput("ovf_flag", overflow, 1);
        checkOutput("ovf_ready_drop", bus.load_ready, 0);
        checkOutput("ovf_count", loaded_count, 8);
        checkOutput("ovf_hold", cpu_reset, 1);
      end
    end
    bus.load_valid = 1'b0;
    checkOutput("ovf_run", cpu_reset, 0);
    checkOutput("ovf_sticky", overflow, 1);
    checkOutput("ovf_count_sat", loaded_count, 8);
    foreach (ovf_vec[i]) begin
      applyStimulus(ovf_vec[i].pc);
      checkOutput($sformatf("ovf_inst_pc%0d", ovf_vec[i].pc), bus.inst, ovf_vec[i].inst);
    end

    $display("[TB] reload mid-run with one-word program");
    pulseStart(1'b1);
    checkOutput("reload_cpu_reset", cpu_reset, 1);
    checkOutput("reload_count", loaded_count, 0);
    checkOutput("reload_ovf_clear", overflow, 0);
    streamWord(16'hABCD, 1'b1);
    checkOutput("reload_count1", loaded_count, 1);
    checkOutput("reload_ready_drop", bus.load_ready, 0);
    tick();
    tick();
    checkOutput("reload_run", cpu_reset, 0);
    applyStimulus(15'd0);
    checkOutput("reload_inst_pc0", bus.inst, 16'hABCD);
    applyStimulus(15'd1);
    checkOutput("reload_inst_pc1_stale", bus.inst, 0);

    $display("[TB] re-boot, hold abort, halt program");
    pulseStart(1'b0);
    checkOutput("reboot_cpu_reset", cpu_reset, 1);
    checkOutput("reboot_busy", busy, 1);
    checkOutput("reboot_no_ready", bus.load_ready, 0);
    pulseStart(1'b1);
    checkOutput("abort_to_load", bus.load_ready, 1);
    streamWord(16'h0001, 1'b0);
    streamWord(16'hEA87, 1'b1);
    tick();
    tick();
    checkOutput("halt_prog_run", cpu_reset, 0);
    checkOutput("halt_prog_count", loaded_count, 2);

    bus.pc = 15'd0;
    tick();
    bus.pc = 15'd1;
    for (int k = 0; k < 8; k++) tick();
    checkOutput("halt_before_limit", halted, 0);
    tick();
    checkOutput("halt_at_limit", halted, EXP_HALT);
    applyStimulus(15'd1);
    checkOutput("halt_inst_pc1", bus.inst, 16'hEA87);
    pulseStart(1'b0);
    checkOutput("halt_cleared_by_run", halted, 0);
    checkOutput("halt_reboot_hold", cpu_reset, 1);

    $display("[TB] reset keeps memory but clears count");
    reset_n = 1'b0;
    tick();
    checkOutput("rst2_cpu_reset", cpu_reset, 1);
    checkOutput("rst2_count", loaded_count, 0);
    checkOutput("rst2_busy", busy, 0);
    applyStimulus(15'd0);
    checkOutput("rst2_inst", bus.inst, 0);
    reset_n = 1'b1;
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
